// File: rtl/perf_sched_pkg.sv
// Shared types, default sizes and helpers for the performance-counter scheduler.
package perf_sched_pkg;

    localparam int unsigned DefNumEvt = 6;
    localparam int unsigned DefCntW   = 32;
    localparam int unsigned DefWinW   = 16;

    typedef enum logic {MainIdle, MainRun} main_state_e;
    typedef enum logic {DumpIdle, DumpSend} dump_state_e;

    // Word index runs 0..num_evt because word 0 carries the cycle count.
    function automatic int unsigned idx_width(input int unsigned num_evt);
        return $clog2(num_evt + 1);
    endfunction

endpackage

// File: rtl/perf_sched_dump.sv
// Shadow bank and valid/ready serialiser: one word per handshake, word 0 first.
module perf_sched_dump
    import perf_sched_pkg::*;
#(
    parameter int unsigned NUM_EVT = DefNumEvt,
    parameter int unsigned CNT_W   = DefCntW
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          launch_i,
    input  logic [NUM_EVT:0][CNT_W-1:0]   snap_i,
    output logic                          busy_o,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [idx_width(NUM_EVT)-1:0] idx_o,
    output logic [CNT_W-1:0]              data_o,
    output logic                          last_o
);

    localparam int unsigned     IdxW    = idx_width(NUM_EVT);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_EVT);

    dump_state_e                 state_q, state_d;
    logic [IdxW-1:0]             idx_q, idx_d;
    logic [NUM_EVT:0][CNT_W-1:0] shadow_q;
    logic                        sending, fire, last;

    assign sending = (state_q == DumpSend);
    assign last    = sending && (idx_q == LastIdx);
    assign fire    = sending && ready_i;
    // The last-beat handshake cycle already counts as free for a new launch.
    assign busy_o  = sending && !(fire && last);

    assign valid_o = sending;
    assign idx_o   = idx_q;
    assign data_o  = sending ? shadow_q[idx_q] : '0;
    assign last_o  = last;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (fire) begin
            if (last) begin
                state_d = DumpIdle;
                idx_d   = '0;
            end else begin
                idx_d = idx_q + IdxW'(1);
            end
        end
        if (launch_i) begin
            state_d = DumpSend;
            idx_d   = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= DumpIdle;
            idx_q    <= '0;
            shadow_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (launch_i) begin
                shadow_q <= snap_i;
            end
        end
    end

endmodule

// File: rtl/perf_cnt_sched.sv
// Performance counter controller: run gating, sampling windows, snapshot and dump.
// Define PERF_CNT_WRAP_EN for wrapping counters instead of saturating ones.
module perf_cnt_sched
    import perf_sched_pkg::*;
#(
    parameter int unsigned NUM_EVT = DefNumEvt,
    parameter int unsigned CNT_W   = DefCntW,
    parameter int unsigned WIN_W   = DefWinW
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         start_stop_i,
    input  logic                         clear_i,
    input  logic [WIN_W-1:0]             win_len_i,
    input  logic [NUM_EVT-1:0]           evt_i,
    input  logic                         dump_req_i,
    output logic                         dump_valid_o,
    input  logic                         dump_ready_i,
    output logic [$clog2(NUM_EVT+1)-1:0] dump_idx_o,
    output logic [CNT_W-1:0]             dump_data_o,
    output logic                         dump_last_o,
    output logic                         running_o,
    output logic [NUM_EVT:0]             ovf_o,
    output logic                         overrun_o
);

    localparam int unsigned      NumCnt = NUM_EVT + 1;
    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    main_state_e                 state_q, state_d;
    logic [NUM_EVT:0][CNT_W-1:0] live_q, live_d, live_inc;
    logic [NUM_EVT:0]            ovf_q, ovf_d, ovf_hit, inc;
    logic [WIN_W-1:0]            win_cnt_q, win_cnt_d;
    logic                        dump_req_q, overrun_q, overrun_d;
    logic                        running, win_on, win_expire, snap_req, dump_busy, launch;

    assign running    = (state_q == MainRun);
    assign inc        = running ? {evt_i, 1'b1} : '0;
    assign win_on     = running && (win_len_i != '0);
    assign win_expire = win_on && (win_cnt_q == win_len_i - WIN_W'(1));
    assign snap_req   = (win_expire || (dump_req_i && !dump_req_q)) && !clear_i;
    assign launch     = snap_req && !dump_busy;

    // live_inc is this cycle's post-event value; it is also what a snapshot captures.
    always_comb begin
        live_inc = live_q;
        ovf_hit  = '0;
        for (int unsigned k = 0; k < NumCnt; k++) begin
            if (inc[k]) begin
                if (live_q[k] == CntMax) begin
                    ovf_hit[k] = 1'b1;
`ifdef PERF_CNT_WRAP_EN
                    live_inc[k] = '0;
`endif
                end else begin
                    live_inc[k] = live_q[k] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        live_d    = live_inc;
        ovf_d     = ovf_q | ovf_hit;
        win_cnt_d = win_cnt_q;
        overrun_d = overrun_q | (snap_req & dump_busy);
        if (start_stop_i) begin
            state_d = running ? MainIdle : MainRun;
        end
        if (win_on) begin
            win_cnt_d = win_cnt_q + WIN_W'(1);
        end
        if (win_expire) begin
            live_d    = '0;
            win_cnt_d = '0;
        end
        if (clear_i) begin
            live_d    = '0;
            win_cnt_d = '0;
            ovf_d     = '0;
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= MainIdle;
            live_q     <= '0;
            ovf_q      <= '0;
            win_cnt_q  <= '0;
            dump_req_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            live_q     <= live_d;
            ovf_q      <= ovf_d;
            win_cnt_q  <= win_cnt_d;
            dump_req_q <= dump_req_i;
            overrun_q  <= overrun_d;
        end
    end

    perf_sched_dump #(
        .NUM_EVT (NUM_EVT),
        .CNT_W   (CNT_W)
    ) u_dump (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .launch_i (launch),
        .snap_i   (live_inc),
        .busy_o   (dump_busy),
        .valid_o  (dump_valid_o),
        .ready_i  (dump_ready_i),
        .idx_o    (dump_idx_o),
        .data_o   (dump_data_o),
        .last_o   (dump_last_o)
    );

    assign running_o = running;
    assign ovf_o     = ovf_q;
    assign overrun_o = overrun_q;

endmodule

// File: doc/perf_cnt_sched.md
Name: perf_cnt_sched

Overview:
- Controller and scheduler for the core's performance event counters: cycle, issue, stall and similar events from the ID stage.
- Gates counting into start/stop or fixed-length sampling windows and snapshots the live counters into a shadow bank.
- Serialises the shadow bank over a valid/ready stream to the testbench or debug sink.
- Replaces ad-hoc toggle/print logic with one synthesisable, handshaked block.

Parameters:
- NUM_EVT, 6, number of event inputs; word 0 of each dump is the cycle count.
- CNT_W, 32, width of each counter.
- WIN_W, 16, width of the window-length register.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- start_stop_i  in  1  single-cycle pulse; toggles IDLE/RUN
- clear_i  in  1  zero live counters, window counter and ovf_o
- win_len_i  in  WIN_W  sampling window in cycles; 0 = unbounded
- evt_i  in  NUM_EVT  per-cycle event strobes
- dump_req_i  in  1  level; rising edge requests a snapshot and dump
- dump_valid_o  out  1  stream valid
- dump_ready_i  in  1  stream ready
- dump_idx_o  out  $clog2(NUM_EVT+1)  word index, 0 = cycle count
- dump_data_o  out  CNT_W  word value
- dump_last_o  out  1  high on index NUM_EVT
- running_o  out  1  main FSM in RUN
- ovf_o  out  NUM_EVT+1  sticky overflow per counter
- overrun_o  out  1  sticky; a snapshot was dropped because the dump engine was busy

Behaviour:
- Reset: FSM=IDLE, all live/shadow counters 0, win_cnt 0, dump_req_q 0, dump engine D_IDLE. All outputs 0.
- Main FSM IDLE:
  - Counters hold.
  - start_stop_i -> RUN on the next cycle. Counters are not cleared.
- Main FSM RUN:
  - cycle counter +1 each cycle; counter k +evt_i[k].
  - start_stop_i -> IDLE. That cycle's events are still counted.
- Window:
  - With win_len_i != 0 in RUN, win_cnt increments.
  - When win_cnt == win_len_i-1: shadow <= live values including this cycle's events; live <= 0; win_cnt <= 0; dump is launched. FSM stays in RUN, giving periodic sampling.
  - A window is therefore exactly win_len_i cycles.
  - win_len_i is sampled every cycle. If it is changed below win_cnt, the window ends only after win_cnt wraps; the bench must not do this.
- Dump request:
  - dump_req_i rising edge (dump_req_i & ~dump_req_q) snapshots live counters, including the current cycle if in RUN.
  - Live counters are NOT cleared.
  - Allowed in IDLE or RUN.
- Snapshot while dump engine busy: snapshot dropped, shadow unchanged, overrun_o set. Window clearing of live counters still happens.
- Counter arithmetic: saturating at 2^CNT_W-1. The ovf_o bit for that counter is set when an increment is attempted at max.
- clear_i:
  - Zeroes live counters, win_cnt and ovf_o; overrun_o also cleared.
  - Has priority over events and window expiry in the same cycle: no snapshot, events dropped.
  - Does not disturb a dump in progress.
- rst_i mid-dump aborts the stream immediately: dump_valid_o = 0 next cycle.
- start_stop_i and window expiry in the same cycle: the snapshot is taken, then FSM -> IDLE with live counters 0.
- Dump engine D_IDLE: on launch, next cycle -> D_SEND with idx 0 and valid 1.
- Dump engine D_SEND:
  - idx/data stable while valid & !ready.
  - On valid & ready: idx+1. If idx == NUM_EVT (last), -> D_IDLE with valid 0 next cycle.
  - Throughput is one word per cycle with ready held high.
  - A new launch on the last-beat handshake cycle is accepted (engine counts as free).

Optional Feature:
- PERF_CNT_WRAP_EN defined: counters wrap modulo 2^CNT_W instead of saturating. ovf_o bit is set on each wrap.
- Undefined: saturating as above.

Decomposition:
- perf_sched_pkg:
  - main_state_e {IDLE, RUN}
  - dump_state_e {D_IDLE, D_SEND}
  - default NUM_EVT/CNT_W constants
  - function for index width
- One sub-module, perf_sched_dump: shadow-bank serialiser and handshake, with a launch/busy interface to the parent.

Test Plan:
- start pulse, evt_i[0] high 10 cycles, stop pulse, dump_req_i edge, ready=1 -> 7 beats; idx0 = 11 (cycles incl. stop cycle), idx1 = 10, others 0, last on idx 6.
- win_len_i=8, evt_i[2] high always, ready=1 -> dump every 8 cycles with idx0 = 8, idx3 = 8; live counters restart at 0.
- During a dump, ready toggles 1,0,0,1 -> data/idx held while stalled; no beat lost or duplicated.
- Second dump_req_i edge while D_SEND -> overrun_o = 1; shadow and stream unchanged.
- CNT_W=4, evt_i[1] for 20 cycles -> idx2 = 15, ovf_o[2] = 1. With PERF_CNT_WRAP_EN: idx2 = 4, ovf_o[2] = 1.
- clear_i coincident with window expiry -> no dump, counters 0. rst_i mid-stream -> dump_valid_o = 0 next cycle, all outputs 0.
